// File: rtl/rotary_paddle_decoder_if.sv
// Encoder-side signal bundle for the paddle decoder: raw quadrature inputs,
// the pause control and the decoded paddle position/step pulses.
interface rotary_paddle_decoder_if;
  logic       rota;
  logic       rotb;
  logic       enable;
  logic [9:0] paddle_y;
  logic       step_cw;
  logic       step_ccw;

  modport master (
    output rota,
    output rotb,
    output enable,
    input  paddle_y,
    input  step_cw,
    input  step_ccw
  );

  modport slave (
    input  rota,
    input  rotb,
    input  enable,
    output paddle_y,
    output step_cw,
    output step_ccw
  );
endinterface

// File: rtl/rotary_paddle_decoder.sv
// Turns the rotary encoder's raw quadrature channels into a clamped paddle_y
// for the Pong controller, with sync, debounce, startup guard and detent decode.
module rotary_paddle_decoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP            = 8,
  parameter int PADDLE_MIN      = 0,
  parameter int PADDLE_MAX      = 400,
  parameter int RESET_POS       = 200
) (
  input  logic                   Clock,
  input  logic                   Reset,
  rotary_paddle_decoder_if.slave encBus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  state_t          next_state;
  logic [1:0]      init_cnt;

  // Bit 0 is channel A, bit 1 is channel B.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      level_db;
  logic [CW-1:0]   db_cnt [2];

  logic            a_db;
  logic            b_db;
  logic            a_db_d;
  logic            a_rise;

  logic [9:0]      paddle_q;
  logic            step_cw_q;
  logic            step_ccw_q;
  logic [10:0]     pos_up;
  logic [9:0]      pos_cw;
  logic [9:0]      pos_ccw;

  assign a_db = level_db[0];
  assign b_db = level_db[1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= INIT;
      init_cnt <= 2'd0;
    end else begin
      state <= next_state;
      if (state == INIT)
        init_cnt <= init_cnt + 2'd1;
    end
  end

  always_comb begin
    next_state = state;
    if (state == INIT && init_cnt == 2'd2)
      next_state = RUN;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {encBus.rotb, encBus.rota};
      sync2 <= sync1;
    end
  end

  // During INIT the debounced levels snap to the synchronised inputs so an
  // encoder resting mid-detent at reset is adopted as the starting level.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      level_db  <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else if (state == INIT) begin
      level_db  <= sync2;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != level_db[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            level_db[i] <= sync2[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // The delayed copy follows the INIT snap too, so the first RUN cycle never
  // sees the startup level change as a rising edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      a_db_d <= 1'b0;
    else
      a_db_d <= (state == INIT) ? sync2[0] : a_db;
  end

  assign a_rise = (state == RUN) && a_db && !a_db_d && encBus.enable;

  always_comb begin
    pos_up  = {1'b0, paddle_q} + 11'(STEP);
    pos_cw  = (pos_up > 11'(PADDLE_MAX)) ? 10'(PADDLE_MAX) : pos_up[9:0];
    pos_ccw = ({1'b0, paddle_q} < 11'(PADDLE_MIN + STEP)) ? 10'(PADDLE_MIN)
                                                          : paddle_q - 10'(STEP);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      paddle_q   <= 10'(RESET_POS);
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
    end else begin
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
      if (a_rise) begin
        if (!b_db) begin
          step_cw_q <= 1'b1;
          paddle_q  <= pos_cw;
        end else begin
          step_ccw_q <= 1'b1;
          paddle_q   <= pos_ccw;
        end
      end
    end
  end

  assign encBus.paddle_y = paddle_q;
  assign encBus.step_cw  = step_cw_q;
  assign encBus.step_ccw = step_ccw_q;

endmodule
